// File: rtl/cacheresp_pkg.sv
// Shared types and constants for the cache-test responder.
package cacheresp_pkg;

  localparam int CNT_W   = 16;
  localparam int LAT_W   = 8;
  localparam int PAT_LEN = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIT  = 2'd1,
    MISS = 2'd2
  } state_t;

  // Pattern index walks 0..PAT_LEN-1; index 0 is the miss slot.
  function automatic logic [1:0] next_pidx(input logic [1:0] p);
    return (p == 2'(PAT_LEN - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/cacheresp_lat.sv
// Loadable 8-bit down-counter that saturates at zero; flags zero combinationally.
module cacheresp_lat
  import cacheresp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             zero
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cacheresp.sv
// Stand-in cache responder: accepts one request, stays busy HIT_LAT/MISS_LAT cycles (miss,hit,hit pattern).
// Optional hit/miss completion counters under `CACHERESP_STATS_EN.
module cacheresp
  import cacheresp_pkg::*;
#(
  parameter int HIT_LAT  = 2,
  parameter int MISS_LAT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             done_out,
  output logic             hit_out,
  output logic [CNT_W-1:0] req_count
`ifdef CACHERESP_STATS_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
`endif
);

  if (HIT_LAT < 1 || HIT_LAT > 255 || MISS_LAT < 1 || MISS_LAT > 255) begin : g_bad_lat
    $error("cacheresp: HIT_LAT and MISS_LAT must be in 1..255");
  end

  localparam logic [LAT_W-1:0] HIT_LV  = LAT_W'(HIT_LAT - 1);
  localparam logic [LAT_W-1:0] MISS_LV = LAT_W'(MISS_LAT - 1);

  state_t           state_q, state_d;
  logic [1:0]       pidx_q, pidx_d;
  logic [CNT_W-1:0] req_count_q, req_count_d;
  logic             lat_load;
  logic [LAT_W-1:0] lat_val;
  logic             lat_zero;

  always_comb begin
    state_d     = state_q;
    pidx_d      = pidx_q;
    req_count_d = req_count_q;
    lat_load    = 1'b0;
    lat_val     = '0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          lat_load    = 1'b1;
          pidx_d      = next_pidx(pidx_q);
          req_count_d = req_count_q + 1'b1;
          if (pidx_q == 2'd0) begin
            state_d = MISS;
            lat_val = MISS_LV;
          end else begin
            state_d = HIT;
            lat_val = HIT_LV;
          end
        end
      end
      HIT, MISS: begin
        if (lat_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pidx_q      <= 2'd0;
      req_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pidx_q      <= pidx_d;
      req_count_q <= req_count_d;
    end
  end

  cacheresp_lat u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (lat_val),
    .zero     (lat_zero)
  );

  assign ready_out = (state_q == IDLE);
  assign done_out  = (state_q != IDLE) && lat_zero;
  assign hit_out   = (state_q == HIT);
  assign req_count = req_count_q;

`ifdef CACHERESP_STATS_EN
  logic [CNT_W-1:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (done_out) begin
      if (hit_out) begin
        hit_count_q <= hit_count_q + 1'b1;
      end else begin
        miss_count_q <= miss_count_q + 1'b1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cacheresp.sv
// Scoreboard bench for cacheresp: timing-rule reference model, randomized valid_in stimulus.
module tb_cacheresp;

  localparam int H = 2;
  localparam int M = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out, done_out, hit_out;
  logic [15:0] req_count;
`ifdef CACHERESP_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cacheresp #(.HIT_LAT(H), .MISS_LAT(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .done_out  (done_out),
    .hit_out   (hit_out),
    .req_count (req_count)
`ifdef CACHERESP_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // edge_n = number of rising edges seen so far = index of the next edge
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    bit hit;
    int due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          free_at = 0;
  int          pidx_m = 0;
  logic [15:0] req_m = 16'd0;
  int          hits_m = 0;
  int          misses_m = 0;
  bit          in_rst = 1'b1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: done_out must fire exactly on the due cycle of the oldest accepted request.
  initial begin
    exp_t e;
    bit   exp_done;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        chk(done_out === 1'b0, "done_in_reset", done_out, 0);
      end else begin
        exp_done = (sb.size() > 0) && (sb[0].due == edge_n);
        chk(done_out === exp_done, "done_timing", done_out, exp_done);
        if (exp_done) begin
          e = sb.pop_front();
          if (done_out === 1'b1) begin
            chk(hit_out === e.hit, "hit_class", hit_out, e.hit);
            if (e.hit) hits_m++;
            else misses_m++;
          end
        end
      end
    end
  end

  // One cycle of stimulus, called just after a rising edge.
  task automatic drive(input bit v);
    int lat;
    bit rdy;
    rdy = (edge_n >= free_at);
    chk(ready_out === rdy, "ready", ready_out, rdy);
    chk(req_count === req_m, "req_count", req_count, req_m);
    valid_in = v;
    if (v && rdy) begin
      lat = (pidx_m == 0) ? M : H;
      sb.push_back('{hit: (pidx_m != 0), due: edge_n + lat});
      free_at = edge_n + lat + 1;
      pidx_m  = (pidx_m + 1) % 3;
      req_m   = req_m + 16'd1;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int cycles);
    rst      = 1'b0;
    in_rst   = 1'b1;
    valid_in = 1'b1;
    sb.delete();
    #1;
    chk(ready_out === 1'b1, "rst_ready", ready_out, 1);
    chk(hit_out === 1'b0, "rst_hit", hit_out, 0);
    chk(req_count === 16'd0, "rst_req_count", req_count, 0);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #2;
      chk(ready_out === 1'b1, "rst_ready_hold", ready_out, 1);
      chk(req_count === 16'd0, "rst_req_count_hold", req_count, 0);
    end
    rst      = 1'b1;
    in_rst   = 1'b0;
    free_at  = edge_n;
    pidx_m   = 0;
    req_m    = 16'd0;
    hits_m   = 0;
    misses_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    #2;
    do_reset(3);

    // Continuous valid: transfers at 0,6,9,12,18 relative to release
    for (int i = 0; i < 25; i++) drive(1'b1);

    // Pulse while busy with a miss must be ignored
    guard = 0;
    while (!(edge_n >= free_at && pidx_m == 0) && guard < 50) begin
      drive(edge_n >= free_at);
      guard++;
    end
    chk(guard < 50, "align_miss_guard", guard, 50);
    drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) drive($urandom_range(0, 3) != 0);

    // Reset two cycles after a miss transfer: no done, pattern restarts
    guard = 0;
    while (!(edge_n >= free_at && pidx_m == 0) && guard < 50) begin
      drive(edge_n >= free_at);
      guard++;
    end
    chk(guard < 50, "align_rst_guard", guard, 50);
    drive(1'b1);
    valid_in = 1'b0;
    @(posedge clk);
    #2;
    do_reset(2);
    drive(1'b1);
    for (int i = 0; i < M + 2; i++) drive(1'b0);

    // Request counter wrap
    force dut.req_count_q = 16'hFFFF;
    #1;
    release dut.req_count_q;
    req_m = 16'hFFFF;
    drive(1'b0);
    drive(1'b1);
    for (int i = 0; i < M + 2; i++) drive(1'b0);

    for (int i = 0; i < 200; i++) drive($urandom_range(0, 2) == 0);

    for (int i = 0; i < M + 3; i++) drive(1'b0);
    chk(sb.size() == 0, "drain", sb.size(), 0);
`ifdef CACHERESP_STATS_EN
    chk(hit_count === 16'(hits_m), "hit_count", hit_count, hits_m);
    chk(miss_count === 16'(misses_m), "miss_count", miss_count, misses_m);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheresp.md
# cacheresp

Request-accepting responder that sits on the receive side of the cache-test request handshake, in place of the cache under test. It drives `ready_in` of the request generator, accepts one request per valid/ready transfer, classifies each accepted request as hit or miss from a fixed 3-request pattern, and stays busy for a hit or miss latency before signalling completion and accepting the next request. It keeps a request count so a simulation bench can check throughput against the generator's schedule.

## Interface
- `HIT_LAT`, default 2: busy cycles for a hit, range 1..255.
- `MISS_LAT`, default 5: busy cycles for a miss, range 1..255.
- `clk  input  1`: clock, all state on rising edge.
- `rst  input  1`: reset, asynchronous, active-low.
- `valid_in  input  1`: request present; connects to the generator's `valid_out`.
- `ready_out  output  1`: responder can accept; connects to the generator's `ready_in`.
- `done_out  output  1`: one-cycle pulse, current request completes this cycle.
- `hit_out  output  1`: classification of the request in service; meaningful only while `done_out`=1.
- `req_count  output  16`: number of accepted requests, wraps.
- `hit_count  output  16`: hits completed. Present only with the stats feature.
- `miss_count  output  16`: misses completed. Present only with the stats feature.

## Operation
- States:
  - IDLE: `ready_out`=1.
  - HIT: busy with a hit.
  - MISS: busy with a miss.
- Transfer: a request transfers on a rising edge where `valid_in`=1 and `ready_out`=1.
  - `valid_in` outside IDLE is ignored and produces no side effect.
- Classification: 2-bit pattern index `pidx` cycles 0→1→2→0 and advances on each transfer.
  - `pidx`=0 at transfer → MISS. `pidx`=1 or 2 → HIT.
  - Pattern is miss, hit, hit, repeating.
- On transfer:
  - Enter HIT with `cnt` ← HIT_LAT-1, or MISS with `cnt` ← MISS_LAT-1.
  - `req_count` ← `req_count`+1, modulo 2^16 (0xFFFF→0x0000).
- In HIT or MISS:
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0: return to IDLE.
- `done_out` = (state≠IDLE) & (`cnt`=0), combinational from registers.
- `hit_out` = (state=HIT).
- `cnt` is 8 bits wide. Out-of-range parameter values are an elaboration error.
- Reset (asynchronous, any cycle, including mid-service):
  - State=IDLE, `cnt`=0, `pidx`=0, all counters 0.
  - The request in service is dropped without a `done_out` pulse.
  - Output values during and after reset: `ready_out`=1, `done_out`=0, `hit_out`=0, `req_count`=0.

## Timing
- Transfer at edge t0: `ready_out`=0 from t0 until edge t0+LAT.
- `done_out`=1 in the cycle ending at edge t0+LAT.
- `ready_out`=1 again after edge t0+LAT. The earliest next transfer is edge t0+LAT+1.
- Accept-to-done latency is exactly LAT cycles.
- Minimum request spacing is LAT+1 cycles.
- With LAT=1, `done_out` is high in the single cycle after the transfer edge.
- No combinational path from `valid_in` to any output.

## Configuration
- `CACHERESP_STATS_EN` defined:
  - `hit_count` and `miss_count` ports and registers are present.
  - On a `done_out` cycle's closing edge, the counter selected by `hit_out` increments, 16-bit wrap.
  - Both counters reset to 0.
- `CACHERESP_STATS_EN` undefined: both ports and registers are absent. All other behaviour is identical.

## Structure
- Package `cacheresp_pkg` holds:
  - State typedef: IDLE=2'd0, HIT=2'd1, MISS=2'd2. Value 2'd3 is illegal and recovers to IDLE.
  - Width constants: counter width 16, latency width 8.
  - Pattern length constant 3.
- One sub-module `cacheresp_lat`:
  - Loadable 8-bit down-counter.
  - Inputs: load, load value.
  - Output: `zero`.
  - Async active-low reset to 0.

## Test plan
- Reset held low with `valid_in`=1 → `ready_out`=1, `req_count`=0, no transfer. Release reset, `valid_in`=1 continuously, HIT_LAT=2, MISS_LAT=5:
  - Transfers at edges 0, 6, 9, 12, 18.
  - `hit_out` at done: 0, 1, 1, 0, 1.
- Single-cycle `valid_in` pulse while state=MISS → ignored. `req_count` unchanged, `pidx` unchanged.
- Connected to the request generator (holdoff 80, distance 6) for 200 cycles:
  - Every generator valid cycle coincides with `ready_out`=1.
  - `req_count` equals the generator's valid-cycle count.
- Force `req_count`=0xFFFF, perform one transfer → `req_count`=0x0000.
- Assert `rst` low two cycles after a miss transfer:
  - No `done_out` pulse.
  - After release, the next request is classified miss (`pidx` restarted at 0).
- With `CACHERESP_STATS_EN`, 6 completed requests → `hit_count`=4, `miss_count`=2.
